game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Round sequencer for the two-player door game. Times the play window and latches
//  the correct doors. At timeout it samples both player positions and updates lives.
//  It holds a reveal pause, then starts the next round or ends the game.
//  Feeds screen_drawer (lives, doors, reveal) and the HEX timer (seconds_left).
// PARAMETERS
//  CLK_HZ       25_000_000  clk cycles per second (prescaler terminal count)
//  PLAY_SEC     10          play window length, seconds (1..15)
//  REVEAL_SEC   1           reveal pause length, seconds (>=1)
//  START_LIVES  3           lives per player at game start (1..3)
// PORTS
//  clk            in   1  system clock (VGA pixel clock)
//  reset          in   1  asynchronous, active-high reset
//  start          in   1  level/pulse; new game request, honoured in IDLE/GAME_OVER only
//  door_1_in      in   2  correct door for player 1's next round (ignored if RNG_DOORS_EN)
//  door_2_in      in   2  correct door for player 2's next round (ignored if RNG_DOORS_EN)
//  player_1_pos   in   2  player 1 current door selection
//  player_2_pos   in   2  player 2 current door selection
//  correct_door_1 out  2  latched door for current round
//  correct_door_2 out  2  latched door for current round
//  p1_lives       out  2  player 1 remaining lives
//  p2_lives       out  2  player 2 remaining lives
//  seconds_left   out  4  play countdown, PLAY_SEC..0
//  reveal         out  1  high while in REVEAL
//  round_done     out  1  one-cycle pulse on REVEAL exit
//  game_over      out  1  high in GAME_OVER
//  winner         out  2  00 none, 01 P1, 10 P2, 11 draw; valid when game_over
// BEHAVIOUR
//  Reset: state=IDLE; lives=START_LIVES; seconds_left=PLAY_SEC; doors, winner,
//   reveal, round_done, game_over=0; prescaler=0. Reset mid-round aborts at once.
//  Tick: prescaler counts 0..CLK_HZ-1, 1-cycle tick at CLK_HZ-1, then wraps.
//   Prescaler clears on every state entry, so the first tick is CLK_HZ cycles after entry.
//  IDLE: on start go to PLAY. Latch doors, seconds_left=PLAY_SEC, lives=START_LIVES.
//  PLAY: each tick decrements seconds_left. On the tick where seconds_left==1:
//   seconds_left->0 and state->REVEAL. On the same edge, sample positions.
//   For each player whose pos != correct door, lives-=1, saturating at 0.
//   PLAY lasts exactly PLAY_SEC*CLK_HZ cycles. start is ignored.
//  REVEAL: reveal=1 and doors are held. On REVEAL_SEC-th tick: round_done=1 for 1 cycle.
//   If p1_lives==0 or p2_lives==0 -> GAME_OVER, with winner set on the same edge.
//   Otherwise -> PLAY: latch new doors, seconds_left=PLAY_SEC.
//  winner: P2 out only -> 01; P1 out only -> 10; both out -> 11 (draw).
//  GAME_OVER: all outputs held; start -> PLAY (as IDLE path, lives reloaded, winner=0).
//  Simultaneous: both players miss on the same round -> both decrement on the same edge.
//  Door values 0..3 all legal. No combinational input->output paths.
// CONFIGURATION
//  RNG_DOORS_EN defined: 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset).
//   It advances every clk. Doors latch from lfsr[1:0] / lfsr[3:2]; door_*_in are unused.
//  RNG_DOORS_EN undefined: doors latch from door_1_in / door_2_in; no LFSR logic.
// STRUCTURE
//  Package game_pkg: typedef enum logic [1:0] {IDLE, PLAY, REVEAL, GAME_OVER} round_state_t;
//   typedef logic [1:0] door_t, lives_t; winner codes W_NONE/W_P1/W_P2/W_DRAW.
//  Sub-module sec_tick (parameter CLK_HZ; clk, reset, clear -> tick) holds the prescaler.
//  FSM, countdown, lives and door latches stay in game_round_ctrl.
// TESTING (CLK_HZ=4, PLAY_SEC=3, REVEAL_SEC=1, START_LIVES=3, RNG off)
//  1 reset, start pulse, doors 1/2 -> PLAY; seconds_left 3,2,1,0 at cycles 4,8,12;
//   reveal rises at cycle 12.
//  2 positions equal doors at timeout -> lives stay 3/3.
//   round_done pulse 4 cycles later, then PLAY with seconds_left=3.
//  3 P1 wrong, P2 right for 3 rounds -> p1_lives 2,1,0.
//   GAME_OVER after third reveal; winner=10.
//  4 both wrong every round -> lives decrement together to 0/0; winner=11.
//  5 reset asserted mid-PLAY -> IDLE next instant, lives=3, seconds_left=3.
//   start during PLAY/REVEAL has no effect.
//  6 from GAME_OVER, start -> PLAY, lives 3/3, winner=00, fresh doors latched.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types, winner codes and lives helper for the door-game round sequencer.
package game_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, REVEAL, GAME_OVER} round_state_t;
    typedef logic [1:0] door_t;
    typedef logic [1:0] lives_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    function automatic lives_t sat_dec(input lives_t l);
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

endpackage

// File: rtl/game_round_ctrl_sec_tick.sv
// sec_tick: one-second prescaler; tick pulses at CLK_HZ-1, clear restarts the count.
module sec_tick #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == W'(CLK_HZ - 1);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round FSM, countdown, lives and door latches for the two-player door game.
// Define RNG_DOORS_EN to draw doors from an internal LFSR instead of door_*_in.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ      = 25_000_000,
    parameter int PLAY_SEC    = 10,
    parameter int REVEAL_SEC  = 1,
    parameter int START_LIVES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  door_1_in,
    input  logic [1:0]  door_2_in,
    input  logic [1:0]  player_1_pos,
    input  logic [1:0]  player_2_pos,
    output logic [1:0]  correct_door_1,
    output logic [1:0]  correct_door_2,
    output logic [1:0]  p1_lives,
    output logic [1:0]  p2_lives,
    output logic [3:0]  seconds_left,
    output logic        reveal,
    output logic        round_done,
    output logic        game_over,
    output logic [1:0]  winner
);
    localparam int RW = $clog2(REVEAL_SEC + 1);

    round_state_t state_q, state_d;
    logic [3:0]    secs_q, secs_d;
    door_t         door1_q, door1_d, door2_q, door2_d, new_door_1, new_door_2;
    lives_t        lives1_q, lives1_d, lives2_q, lives2_d;
    logic [1:0]    winner_q, winner_d;
    logic [RW-1:0] rev_q, rev_d;
    logic          round_done_q, tick, clear, rev_done, enter_play, new_game, timeout, out1, out2;

    sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

`ifdef RNG_DOORS_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
    assign new_door_1 = lfsr_q[1:0];
    assign new_door_2 = lfsr_q[3:2];
`else
    assign new_door_1 = door_1_in;
    assign new_door_2 = door_2_in;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    assign rev_done = state_q == REVEAL && tick && rev_q == RW'(REVEAL_SEC - 1);
    assign out1     = lives1_q == '0;
    assign out2     = lives2_q == '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, GAME_OVER: state_d = start ? PLAY : state_q;
            PLAY:            state_d = (tick && secs_q == 4'd1) ? REVEAL : PLAY;
            REVEAL:          state_d = rev_done ? ((out1 || out2) ? GAME_OVER : PLAY) : REVEAL;
        endcase
    end

    // Every state entry restarts the prescaler so each phase lasts whole seconds.
    assign clear      = state_d != state_q;
    assign enter_play = state_d == PLAY && state_q != PLAY;
    assign new_game   = enter_play && state_q != REVEAL;
    assign timeout    = state_q == PLAY && state_d == REVEAL;

    always_comb begin
        secs_d   = enter_play ? 4'(PLAY_SEC) : (state_q == PLAY && tick) ? secs_q - 4'd1 : secs_q;
        door1_d  = enter_play ? new_door_1 : door1_q;
        door2_d  = enter_play ? new_door_2 : door2_q;
        lives1_d = new_game ? lives_t'(START_LIVES) :
                   (timeout && player_1_pos != door1_q) ? sat_dec(lives1_q) : lives1_q;
        lives2_d = new_game ? lives_t'(START_LIVES) :
                   (timeout && player_2_pos != door2_q) ? sat_dec(lives2_q) : lives2_q;
        winner_d = new_game ? W_NONE :
                   !(rev_done && state_d == GAME_OVER) ? winner_q :
                   (out1 && out2) ? W_DRAW : out1 ? W_P2 : W_P1;
        rev_d    = state_q != REVEAL ? '0 : tick ? rev_q + 1'b1 : rev_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            secs_q       <= 4'(PLAY_SEC);
            door1_q      <= '0;
            door2_q      <= '0;
            lives1_q     <= lives_t'(START_LIVES);
            lives2_q     <= lives_t'(START_LIVES);
            winner_q     <= W_NONE;
            rev_q        <= '0;
            round_done_q <= 1'b0;
        end else begin
            secs_q       <= secs_d;
            door1_q      <= door1_d;
            door2_q      <= door2_d;
            lives1_q     <= lives1_d;
            lives2_q     <= lives2_d;
            winner_q     <= winner_d;
            rev_q        <= rev_d;
            round_done_q <= rev_done;
        end

    always_comb begin
        reveal    = state_q == REVEAL;
        game_over = state_q == GAME_OVER;
    end

    assign correct_door_1 = door1_q;
    assign correct_door_2 = door2_q;
    assign p1_lives       = lives1_q;
    assign p2_lives       = lives2_q;
    assign seconds_left   = secs_q;
    assign round_done     = round_done_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: table-driven rounds plus random games checked against a lives/winner model.
module tb_game_round_ctrl;

    localparam int CLK_HZ = 4, PLAY_SEC = 3, REVEAL_SEC = 1, START_LIVES = 3;

    logic       clk = 0, reset, start;
    logic [1:0] door_1_in, door_2_in, player_1_pos, player_2_pos;
    logic [1:0] correct_door_1, correct_door_2, p1_lives, p2_lives, winner;
    logic [3:0] seconds_left;
    logic       reveal, round_done, game_over;

    int n_chk = 0, n_fail = 0;

    game_round_ctrl #(.CLK_HZ(CLK_HZ), .PLAY_SEC(PLAY_SEC), .REVEAL_SEC(REVEAL_SEC),
                      .START_LIVES(START_LIVES)) dut (
        .clk(clk), .reset(reset), .start(start),
        .door_1_in(door_1_in), .door_2_in(door_2_in),
        .player_1_pos(player_1_pos), .player_2_pos(player_2_pos),
        .correct_door_1(correct_door_1), .correct_door_2(correct_door_2),
        .p1_lives(p1_lives), .p2_lives(p2_lives), .seconds_left(seconds_left),
        .reveal(reveal), .round_done(round_done), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] d1, d2, p1, p2;
        int         l1, l2;
        bit         over;
        logic [1:0] win;
    } round_vec_t;

    round_vec_t tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [1:0] d1, input logic [1:0] d2);
        door_1_in = d1;
        door_2_in = d2;
        start = 1;
        edges(1);
        start = 0;
        chk("new_game_p1_lives", p1_lives, START_LIVES);
        chk("new_game_p2_lives", p2_lives, START_LIVES);
        chk("new_game_winner", winner, 2'b00);
        chk("new_game_over", game_over, 0);
    endtask

    // Called just after the edge that entered PLAY; returns just after the reveal-exit edge.
    task automatic do_round(input logic [1:0] d1, d2, p1, p2, nd1, nd2,
                            input int el1, el2, input bit eover, input logic [1:0] ewin,
                            input bit rs);
        chk("entry_door1", correct_door_1, d1);
        chk("entry_door2", correct_door_2, d2);
        chk("entry_secs", seconds_left, PLAY_SEC);
        chk("entry_reveal", reveal, 0);
        player_1_pos = p1;
        player_2_pos = p2;
        door_1_in = nd1;
        door_2_in = nd2;
        start = rs;
        edges(CLK_HZ - 1);
        chk("secs_before_tick", seconds_left, PLAY_SEC);
        edges(1);
        chk("secs_first_tick", seconds_left, PLAY_SEC - 1);
        edges(PLAY_SEC * CLK_HZ - CLK_HZ - 1);
        chk("secs_last", seconds_left, 1);
        chk("reveal_early", reveal, 0);
        edges(1);
        chk("secs_zero", seconds_left, 0);
        chk("reveal_high", reveal, 1);
        chk("round_p1_lives", p1_lives, el1);
        chk("round_p2_lives", p2_lives, el2);
        chk("reveal_door1_held", correct_door_1, d1);
        edges(REVEAL_SEC * CLK_HZ - 1);
        chk("reveal_still", reveal, 1);
        chk("round_done_early", round_done, 0);
        start = 0;
        edges(1);
        chk("round_done_pulse", round_done, 1);
        chk("reveal_exit", reveal, 0);
        chk("game_over", game_over, eover);
        chk("winner", winner, eover ? ewin : 2'b00);
        if (!eover) begin
            chk("next_secs", seconds_left, PLAY_SEC);
            chk("next_door1", correct_door_1, nd1);
            chk("next_door2", correct_door_2, nd2);
        end else begin
            edges(1);
            chk("round_done_single", round_done, 0);
            chk("game_over_hold", game_over, 1);
            chk("over_lives_hold", p1_lives, el1);
        end
    endtask

    initial begin
        int ml1, ml2, guard;
        bit over;
        logic [1:0] d1, d2, nd1, nd2, p1, p2;
        tab[0] = '{2'd1, 2'd2, 2'd1, 2'd2, 3, 3, 0, 2'b00};
        tab[1] = '{2'd0, 2'd3, 2'd1, 2'd3, 2, 3, 0, 2'b00};
        tab[2] = '{2'd3, 2'd1, 2'd0, 2'd1, 1, 3, 0, 2'b00};
        tab[3] = '{2'd2, 2'd0, 2'd3, 2'd0, 0, 3, 1, 2'b10};
        tab[4] = '{2'd1, 2'd1, 2'd2, 2'd0, 2, 2, 0, 2'b00};
        tab[5] = '{2'd2, 2'd3, 2'd0, 2'd0, 1, 1, 0, 2'b00};
        tab[6] = '{2'd0, 2'd2, 2'd3, 2'd3, 0, 0, 1, 2'b11};
        tab[7] = '{2'd3, 2'd3, 2'd3, 2'd0, 3, 2, 0, 2'b00};
        tab[8] = '{2'd1, 2'd0, 2'd1, 2'd1, 3, 1, 0, 2'b00};
        tab[9] = '{2'd2, 2'd2, 2'd2, 2'd1, 3, 0, 1, 2'b01};

        reset = 1; start = 0;
        door_1_in = 0; door_2_in = 0; player_1_pos = 0; player_2_pos = 0;
        edges(2);
        chk("rst_p1_lives", p1_lives, START_LIVES);
        chk("rst_p2_lives", p2_lives, START_LIVES);
        chk("rst_secs", seconds_left, PLAY_SEC);
        chk("rst_door1", correct_door_1, 0);
        chk("rst_reveal", reveal, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        reset = 0;
        edges(6);
        chk("idle_no_countdown", seconds_left, PLAY_SEC);

        start_game(tab[0].d1, tab[0].d2);
        for (int i = 0; i < 10; i++) begin
            nd1 = (i < 9) ? tab[i+1].d1 : 2'd0;
            nd2 = (i < 9) ? tab[i+1].d2 : 2'd0;
            do_round(tab[i].d1, tab[i].d2, tab[i].p1, tab[i].p2, nd1, nd2,
                     tab[i].l1, tab[i].l2, tab[i].over, tab[i].win, i[0]);
            if (tab[i].over && i < 9) start_game(tab[i+1].d1, tab[i+1].d2);
        end

        // Reset in the middle of a PLAY window, after a life was lost.
        start_game(2'd2, 2'd1);
        do_round(2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd3, 2, 3, 0, 2'b00, 1);
        edges(5);
        #2 reset = 1;
        #1;
        chk("midrst_p1_lives", p1_lives, START_LIVES);
        chk("midrst_secs", seconds_left, PLAY_SEC);
        chk("midrst_door1", correct_door_1, 0);
        chk("midrst_reveal", reveal, 0);
        edges(1);
        reset = 0;
        edges(3 * CLK_HZ);
        chk("midrst_idle", seconds_left, PLAY_SEC);

        for (int g = 0; g < 5; g++) begin
            d1 = 2'($urandom); d2 = 2'($urandom);
            ml1 = START_LIVES; ml2 = START_LIVES;
            start_game(d1, d2);
            over = 0; guard = 0;
            while (!over && guard < 20) begin
                p1 = ($urandom_range(0, 1) == 1) ? d1 : 2'($urandom);
                p2 = ($urandom_range(0, 1) == 1) ? d2 : 2'($urandom);
                nd1 = 2'($urandom); nd2 = 2'($urandom);
                if (p1 != d1 && ml1 > 0) ml1--;
                if (p2 != d2 && ml2 > 0) ml2--;
                over = ml1 == 0 || ml2 == 0;
                do_round(d1, d2, p1, p2, nd1, nd2, ml1, ml2, over,
                         {1'(ml1 == 0), 1'(ml2 == 0)}, 1'($urandom));
                d1 = nd1; d2 = nd2;
                guard++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
